secuenciador_compuerta: RTL and testbench

//  Self-test sequencer for the combinational gate datapath (2-input AND by default).
//  On Inicio it walks Entrada_Dut through every input combination from 0 to 2^ANCHO-1.
//  It waits ESPERA cycles, samples Salida_Dut, compares it against the truth table TABLA,
//  and reports Fin, Error, an error count and the first failing vector.
//  It sits between the board-level start button/LEDs and the gate under test.

---
 rtl/secuenciador_compuerta.sv | 118 +++++++++++
 tb/tb_secuenciador_compuerta.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_compuerta.sv
// Self-test sequencer for a combinational gate: walks every input vector, waits for the
// gate to settle, samples its output, compares it with TABLA, and keeps a running error summary.
module secuenciador_compuerta #(
    parameter int                  ANCHO  = 2,
    parameter int                  ESPERA = 2,
    parameter logic [2**ANCHO-1:0] TABLA  = 4'b1000
) (
    input  logic             Reloj,
    input  logic             Reset_n,
    input  logic             Inicio,
    input  logic             Salida_Dut,
    output logic [ANCHO-1:0] Entrada_Dut,
    output logic             Ocupado,
    output logic             Fin,
    output logic             Error,
    output logic [ANCHO:0]   Cuenta_Errores,
    output logic [ANCHO-1:0] Primer_Fallo,
    output logic [1:0]       estado_dbg
);

    // Handshake: Inicio is a level request, honoured only in REPOSO or FIN; Ocupado=1 means
    // the request is being served and further Inicio levels are ignored until Fin=1.

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        APLICA   = 2'd1,
        MUESTREA = 2'd2,
        FIN      = 2'd3
    } estado_t;

    localparam int             EW         = (ESPERA > 1) ? $clog2(ESPERA) : 1;
    localparam logic [EW-1:0]  ESPERA_ULT = EW'(ESPERA - 1);
    localparam logic [ANCHO:0] ULTIMO     = {1'b0, {ANCHO{1'b1}}};

    estado_t          estado, estado_sig;
    logic [ANCHO:0]   vector, vector_sig;
    logic [EW-1:0]    espera, espera_sig;
    logic             error_sig;
    logic [ANCHO:0]   cuenta_sig;
    logic [ANCHO-1:0] primer_sig;
    logic             ocupado_sig;
    logic             fin_sig;
    logic [ANCHO-1:0] entrada_sig;

    always_comb begin
        estado_sig = estado;
        vector_sig = vector;
        espera_sig = espera;
        error_sig  = Error;
        cuenta_sig = Cuenta_Errores;
        primer_sig = Primer_Fallo;

        case (estado)
            REPOSO, FIN: begin
                if (Inicio) begin
                    estado_sig = APLICA;
                    vector_sig = '0;
                    espera_sig = '0;
                    error_sig  = 1'b0;
                    cuenta_sig = '0;
                    primer_sig = '0;
                end
            end
            APLICA: begin
                if (espera == ESPERA_ULT) estado_sig = MUESTREA;
                else                      espera_sig = espera + 1'b1;
            end
            MUESTREA: begin
                if (Salida_Dut != TABLA[vector[ANCHO-1:0]]) begin
                    cuenta_sig = Cuenta_Errores + 1'b1;
                    error_sig  = 1'b1;
                    if (!Error) primer_sig = vector[ANCHO-1:0];
                end
                // The run ends on the last-vector compare; the extra vector bit never wraps.
                if (vector == ULTIMO) begin
                    estado_sig = FIN;
                end else begin
                    vector_sig = vector + 1'b1;
                    espera_sig = '0;
                    estado_sig = APLICA;
                end
            end
            default: estado_sig = REPOSO;
        endcase

        // Outputs are computed from the next state so that they come straight out of flops.
        ocupado_sig = (estado_sig == APLICA) || (estado_sig == MUESTREA);
        fin_sig     = (estado_sig == FIN);
        entrada_sig = ocupado_sig ? vector_sig[ANCHO-1:0] : '0;
    end

    always_ff @(posedge Reloj or negedge Reset_n) begin
        if (!Reset_n) begin
            estado         <= REPOSO;
            vector         <= '0;
            espera         <= '0;
            Error          <= 1'b0;
            Cuenta_Errores <= '0;
            Primer_Fallo   <= '0;
            Ocupado        <= 1'b0;
            Fin            <= 1'b0;
            Entrada_Dut    <= '0;
        end else begin
            estado         <= estado_sig;
            vector         <= vector_sig;
            espera         <= espera_sig;
            Error          <= error_sig;
            Cuenta_Errores <= cuenta_sig;
            Primer_Fallo   <= primer_sig;
            Ocupado        <= ocupado_sig;
            Fin            <= fin_sig;
            Entrada_Dut    <= entrada_sig;
        end
    end

    assign estado_dbg = estado;

endmodule

// File: tb/tb_secuenciador_compuerta.sv
// Bench for secuenciador_compuerta: a default 2-input instance exercised against several
// gate behaviours, plus a 3-input instance with a one-cycle settle time.
module tb_secuenciador_compuerta;

    // ---------------- clock / reset ----------------
    logic Reloj = 1'b0;
    always #5 Reloj = ~Reloj;

    logic       Reset_n;
    logic       Inicio;
    logic       Salida_Dut;
    logic [1:0] Entrada_Dut;
    logic       Ocupado, Fin, Error;
    logic [2:0] Cuenta_Errores;
    logic [1:0] Primer_Fallo;
    logic [1:0] estado_dbg;

    logic       Inicio2;
    logic       Salida2;
    logic [2:0] Entrada2;
    logic       Ocupado2, Fin2, Error2;
    logic [3:0] Cuenta2;
    logic [2:0] Primer2;
    logic [1:0] estado2;

    secuenciador_compuerta dut (
        .Reloj          (Reloj),
        .Reset_n        (Reset_n),
        .Inicio         (Inicio),
        .Salida_Dut     (Salida_Dut),
        .Entrada_Dut    (Entrada_Dut),
        .Ocupado        (Ocupado),
        .Fin            (Fin),
        .Error          (Error),
        .Cuenta_Errores (Cuenta_Errores),
        .Primer_Fallo   (Primer_Fallo),
        .estado_dbg     (estado_dbg)
    );

    secuenciador_compuerta #(.ANCHO(3), .ESPERA(1), .TABLA(8'h80)) dut2 (
        .Reloj          (Reloj),
        .Reset_n        (Reset_n),
        .Inicio         (Inicio2),
        .Salida_Dut     (Salida2),
        .Entrada_Dut    (Entrada2),
        .Ocupado        (Ocupado2),
        .Fin            (Fin2),
        .Error          (Error2),
        .Cuenta_Errores (Cuenta2),
        .Primer_Fallo   (Primer2),
        .estado_dbg     (estado2)
    );

    // ---------------- gate models under test ----------------
    int modo = 0;

    function automatic logic compuerta(input int m, input int v);
        logic a, b;
        a = v[0];
        b = v[1];
        case (m)
            0:       return a & b;
            1:       return 1'b1;
            2:       return a | b;
            3:       return a ^ b;
            4:       return 1'b0;
            5:       return ~(a & b);
            default: return 1'b0;
        endcase
    endfunction

    always_comb Salida_Dut = compuerta(modo, int'(Entrada_Dut));
    always_comb Salida2    = &Entrada2;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nombre, act, exp);
        end
    endtask

    task automatic chk_reposo(input string etiqueta);
        chk({etiqueta, " entrada"}, 32'(Entrada_Dut), 0);
        chk({etiqueta, " ocupado"}, 32'(Ocupado), 0);
        chk({etiqueta, " fin"}, 32'(Fin), 0);
        chk({etiqueta, " error"}, 32'(Error), 0);
        chk({etiqueta, " cuenta"}, 32'(Cuenta_Errores), 0);
        chk({etiqueta, " primer"}, 32'(Primer_Fallo), 0);
        chk({etiqueta, " estado"}, 32'(estado_dbg), 0);
    endtask

    // ---------------- driver: one full run, checked cycle by cycle ----------------
    // Ends on the negedge of the first FIN cycle (cycle 13 counted from the start edge).
    task automatic correr(input int m, input logic sostener);
        int cnt_exp;
        logic err_exp;
        int v;
        @(negedge Reloj);
        modo   = m;
        Inicio = 1'b1;
        @(posedge Reloj);
        @(negedge Reloj);
        if (!sostener) Inicio = 1'b0;
        cnt_exp = 0;
        err_exp = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            v = (k - 1) / 3;
            chk($sformatf("m%0d c%0d entrada", m, k), 32'(Entrada_Dut), 32'(v));
            chk($sformatf("m%0d c%0d ocupado", m, k), 32'(Ocupado), 1);
            chk($sformatf("m%0d c%0d fin", m, k), 32'(Fin), 0);
            chk($sformatf("m%0d c%0d error", m, k), 32'(Error), 32'(err_exp));
            chk($sformatf("m%0d c%0d cuenta", m, k), 32'(Cuenta_Errores), 32'(cnt_exp));
            if (((k - 1) % 3 == 2) && (compuerta(m, v) != (v == 3))) begin
                cnt_exp++;
                err_exp = 1'b1;
            end
            @(negedge Reloj);
        end
        chk($sformatf("m%0d c13 fin", m), 32'(Fin), 1);
        chk($sformatf("m%0d c13 ocupado", m), 32'(Ocupado), 0);
        chk($sformatf("m%0d c13 entrada", m), 32'(Entrada_Dut), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int   modo;
        logic exp_error;
        int   exp_cuenta;
        int   exp_primer;
    } caso_t;

    caso_t casos[6];

    initial begin
        int n;
        casos[0] = '{modo: 0, exp_error: 1'b0, exp_cuenta: 0, exp_primer: 0}; // correct AND
        casos[1] = '{modo: 1, exp_error: 1'b1, exp_cuenta: 3, exp_primer: 0}; // stuck-at-1
        casos[2] = '{modo: 2, exp_error: 1'b1, exp_cuenta: 2, exp_primer: 1}; // OR
        casos[3] = '{modo: 3, exp_error: 1'b1, exp_cuenta: 3, exp_primer: 1}; // XOR
        casos[4] = '{modo: 4, exp_error: 1'b1, exp_cuenta: 1, exp_primer: 3}; // stuck-at-0
        casos[5] = '{modo: 5, exp_error: 1'b1, exp_cuenta: 4, exp_primer: 0}; // NAND, full count

        Reset_n = 1'b0;
        Inicio  = 1'b0;
        Inicio2 = 1'b0;
        repeat (3) @(negedge Reloj);
        chk_reposo("reset");
        chk("reset dut2 fin", 32'(Fin2), 0);
        chk("reset dut2 error", 32'(Error2), 0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Reloj);
        chk_reposo("idle");

        foreach (casos[i]) begin
            correr(casos[i].modo, 1'b0);
            chk($sformatf("t%0d error", i), 32'(Error), 32'(casos[i].exp_error));
            chk($sformatf("t%0d cuenta", i), 32'(Cuenta_Errores), 32'(casos[i].exp_cuenta));
            if (casos[i].exp_error)
                chk($sformatf("t%0d primer", i), 32'(Primer_Fallo), 32'(casos[i].exp_primer));
            @(negedge Reloj);
            chk($sformatf("t%0d fin held", i), 32'(Fin), 1);
            chk($sformatf("t%0d cuenta held", i), 32'(Cuenta_Errores), 32'(casos[i].exp_cuenta));
        end

        // Inicio held for a whole run: not restarted mid-run, immediate restart from FIN.
        correr(1, 1'b1);
        chk("hold c13 cuenta", 32'(Cuenta_Errores), 3);
        @(negedge Reloj);
        chk("hold c14 fin", 32'(Fin), 0);
        chk("hold c14 ocupado", 32'(Ocupado), 1);
        chk("hold c14 entrada", 32'(Entrada_Dut), 0);
        chk("hold c14 error", 32'(Error), 0);
        chk("hold c14 cuenta", 32'(Cuenta_Errores), 0);
        Inicio = 1'b0;
        n = 0;
        while (!Fin && n < 40) begin
            @(negedge Reloj);
            n++;
        end
        chk("hold second run fin", 32'(Fin), 1);
        chk("hold second run cuenta", 32'(Cuenta_Errores), 3);

        // Reset during vector 2 of a failing run.
        @(negedge Reloj);
        modo   = 1;
        Inicio = 1'b1;
        @(posedge Reloj);
        @(negedge Reloj);
        Inicio = 1'b0;
        repeat (7) @(negedge Reloj);
        chk("pre-reset entrada", 32'(Entrada_Dut), 2);
        chk("pre-reset cuenta", 32'(Cuenta_Errores), 2);
        #1 Reset_n = 1'b0;
        #1 chk_reposo("async reset");
        @(negedge Reloj);
        Reset_n = 1'b1;
        correr(0, 1'b0);
        chk("after reset error", 32'(Error), 0);
        chk("after reset cuenta", 32'(Cuenta_Errores), 0);

        // 3-input AND, one settle cycle: 16 cycles, vectors 0..7.
        @(negedge Reloj);
        Inicio2 = 1'b1;
        @(posedge Reloj);
        @(negedge Reloj);
        Inicio2 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("w3 c%0d entrada", k), 32'(Entrada2), 32'((k - 1) / 2));
            chk($sformatf("w3 c%0d ocupado", k), 32'(Ocupado2), 1);
            chk($sformatf("w3 c%0d fin", k), 32'(Fin2), 0);
            @(negedge Reloj);
        end
        chk("w3 c17 fin", 32'(Fin2), 1);
        chk("w3 c17 error", 32'(Error2), 0);
        chk("w3 c17 cuenta", 32'(Cuenta2), 0);
        chk("w3 c17 entrada", 32'(Entrada2), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
